// File: rtl/fetch_pkg.sv
// Shared fetch-path constants and the {pc, inst} entry carried from imem to decode.
package fetch_pkg;

    localparam int FETCH_ADDR_W = 32;
    localparam int FETCH_INST_W = 32;
    localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_PC = 32'hBFC0_0000;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear and occupancy count; 1-cycle write-to-read latency.
// Push while full is dropped unless a pop happens in the same cycle; pop while empty is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign do_pop   = pop && (count != '0);
    assign do_push  = push && ((count != CW'(DEPTH)) || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch front end: credit-limited imem requests, in-order responses into a DEPTH-entry queue, 1-cycle resp-to-decode
// (0 with FETCH_BYPASS_EN); issue stalls on outstanding/queue credit, redirect flushes and squashes in-flight responses.
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W          = FETCH_ADDR_W,
    parameter int                INST_W          = FETCH_INST_W,
    parameter int                DEPTH           = 4,
    parameter int                MAX_OUTSTANDING = 2,
    parameter logic [ADDR_W-1:0] RESET_PC        = ADDR_W'(FETCH_RESET_PC)
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         imem_req_valid,
    input  logic                         imem_req_ready,
    output logic [ADDR_W-1:0]            imem_req_addr,
    input  logic                         imem_resp_valid,
    input  logic [INST_W-1:0]            imem_resp_data,
    input  logic                         redirect_valid,
    input  logic [ADDR_W-1:0]            redirect_pc,
    output logic                         de_valid,
    input  logic                         de_ready,
    output logic [ADDR_W-1:0]            de_pc,
    output logic [INST_W-1:0]            de_inst,
    output logic [$clog2(DEPTH+1)-1:0]   fq_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW = ((OW > CW) ? OW : CW) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    logic [ADDR_W-1:0] pc;
    logic [OW-1:0]     outstanding;
    logic [OW-1:0]     discard;
    logic [ADDR_W-1:0] tag_pc;
    entry_t            q_in;
    entry_t            q_head;
    logic [CW-1:0]     q_count;
    logic [SW-1:0]     committed;
    logic              q_empty;
    logic              fire;
    logic              resp_ok;
    logic              resp_live;
    logic              bypass;
    logic              enq;
    logic              deq;

    // Every live in-flight request owns a queue slot, so responses never need backpressure.
    assign committed      = SW'(outstanding - discard) + SW'(q_count);
    assign imem_req_valid = !reset && (outstanding < OW'(MAX_OUTSTANDING)) && (committed < SW'(DEPTH));
    assign imem_req_addr  = pc;
    assign fire           = imem_req_valid && imem_req_ready;

    assign resp_ok   = !reset && imem_resp_valid && (outstanding != '0);
    assign resp_live = resp_ok && (discard == '0) && !redirect_valid;
    assign q_empty   = (q_count == '0);

`ifdef FETCH_BYPASS_EN
    assign bypass = resp_live && q_empty;
`else
    assign bypass = 1'b0;
`endif

    assign de_valid = !reset && (!q_empty || bypass);
    assign de_pc    = bypass ? tag_pc : q_head.pc;
    assign de_inst  = bypass ? imem_resp_data : q_head.inst;
    assign deq      = de_valid && de_ready && !q_empty;
    assign enq      = resp_live && !(bypass && de_ready);
    assign q_in     = '{pc: tag_pc, inst: imem_resp_data};
    assign fq_count = q_count;

    // Tag FIFO occupancy doubles as the outstanding-request count; it survives redirects.
    sync_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (1'b0),
        .push      (fire),
        .push_data (pc),
        .pop       (resp_ok),
        .pop_data  (tag_pc),
        .count     (outstanding)
    );

    sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_inst_queue (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect_valid),
        .push      (enq),
        .push_data (q_in),
        .pop       (deq),
        .pop_data  (q_head),
        .count     (q_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= RESET_PC;
            discard <= '0;
        end else begin
            if (redirect_valid) begin
                pc <= redirect_pc;
            end else if (fire) begin
                pc <= pc + ADDR_W'(4);
            end
            // Everything still in flight after this edge, including a request firing now, is stale.
            if (redirect_valid) begin
                discard <= outstanding + OW'(fire) - OW'(resp_ok);
            end else if (resp_ok && (discard != '0)) begin
                discard <= discard - OW'(1);
            end
        end
    end

    resp_needs_request: assert property (@(posedge clk) disable iff (reset)
        imem_resp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: in-order imem model plus a decode-side scoreboard.
module tb_fetch_queue_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        de_valid;
    logic        de_ready = 1'b0;
    logic [31:0] de_pc;
    logic [31:0] de_inst;
    logic [2:0]  fq_count;

    fetch_queue_unit dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .de_valid        (de_valid),
        .de_ready        (de_ready),
        .de_pc           (de_pc),
        .de_inst         (de_inst),
        .fq_count        (fq_count)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t        pend_q[$];
    fetch_entry_t exp_q[$];
    logic [31:0]  addr_log[$];

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   fire_cnt = 0;
    int   mem_lat = 1;
    logic mem_rdy = 1'b1;

    logic        snap_de_valid;
    logic [31:0] snap_de_pc;
    logic [31:0] snap_de_inst;
    logic        snap_resp_valid;
    logic        snap_fire;
    logic        snap_hs;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h2400_0001;
    endfunction

    // Memory: answers in order mem_lat edges after the request fires.
    task automatic mem_step();
        pend_t        p;
        fetch_entry_t e;
        imem_req_ready  = mem_rdy;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if (pend_q.size() > 0 && pend_q[0].due <= cyc + 1) begin
            p = pend_q.pop_front();
            imem_resp_valid = 1'b1;
            imem_resp_data  = inst_of(p.addr);
        end
        if (imem_req_valid && imem_req_ready) begin
            p.addr = imem_req_addr;
            p.due  = cyc + 1 + mem_lat;
            pend_q.push_back(p);
            e.pc   = imem_req_addr;
            e.inst = inst_of(imem_req_addr);
            exp_q.push_back(e);
            addr_log.push_back(imem_req_addr);
            fire_cnt++;
        end
    endtask

    task automatic mon_step();
        fetch_entry_t e;
        snap_de_valid   = de_valid;
        snap_de_pc      = de_pc;
        snap_de_inst    = de_inst;
        snap_resp_valid = imem_resp_valid;
        snap_fire       = imem_req_valid && imem_req_ready;
        snap_hs         = !reset && de_valid && de_ready;
        if (snap_hs) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_underflow: decode took pc=%h inst=%h, nothing expected", de_pc, de_inst);
            end else begin
                e = exp_q.pop_front();
                if (de_pc !== e.pc || de_inst !== e.inst) begin
                    miscompares++;
                    $display("FAIL sb_decode: got pc=%h inst=%h, expected pc=%h inst=%h",
                             de_pc, de_inst, e.pc, e.inst);
                end
            end
        end
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
    task automatic tick();
        #1;
        mem_step();
        @(negedge clk);
        mon_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic apply_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        de_ready       = 1'b0;
        mem_rdy        = 1'b1;
        mem_lat        = 1;
        pend_q.delete();
        exp_q.delete();
        addr_log.delete();
        fire_cnt = 0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
        exp_q.delete();
        addr_log.delete();
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        de_ready = 1'b0;
        pend_q.delete();
        exp_q.delete();
        addr_log.delete();
        fire_cnt = 0;
        repeat (2) tick();
        vectors++;
        if (imem_req_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_req_valid: got %b, expected 0", imem_req_valid);
        end
        vectors++;
        if (de_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_de_valid: got %b, expected 0", de_valid);
        end
        vectors++;
        if (fq_count !== 3'd0) begin
            miscompares++; $display("FAIL reset_fq_count: got %0d, expected 0", fq_count);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hBFC0_0000) begin
            miscompares++;
            $display("FAIL reset_first_req: got valid=%b addr=%h, expected valid=1 addr=bfc00000",
                     imem_req_valid, imem_req_addr);
        end
        tick();
    endtask

    task automatic test_stream();
        bit found = 0;
        int gaps = 0;
        apply_reset();
        de_ready = 1'b1;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            found = snap_de_valid;
        end
        vectors++;
        if (!found) begin
            miscompares++; $display("FAIL stream_start: de_valid got 0 for 10 cycles, expected 1");
        end
        repeat (16) begin
            tick();
            if (!snap_de_valid) gaps++;
        end
        vectors++;
        if (gaps != 0) begin
            miscompares++; $display("FAIL stream_gaps: got %0d idle decode cycles, expected 0", gaps);
        end
    endtask

    task automatic test_backpressure();
        int base;
        apply_reset();
        de_ready = 1'b0;
        repeat (12) tick();
        vectors++;
        if (fq_count !== 3'd4) begin
            miscompares++; $display("FAIL bp_full_count: got %0d, expected 4", fq_count);
        end
        vectors++;
        if (imem_req_valid !== 1'b0) begin
            miscompares++; $display("FAIL bp_req_stall: got %b, expected 0", imem_req_valid);
        end
        vectors++;
        if (fire_cnt != 4) begin
            miscompares++; $display("FAIL bp_fires: got %0d, expected 4", fire_cnt);
        end
        de_ready = 1'b1;
        tick();
        de_ready = 1'b0;
        vectors++;
        if (snap_hs !== 1'b1 || snap_de_pc !== 32'hBFC0_0000) begin
            miscompares++;
            $display("FAIL bp_pop: got hs=%b pc=%h, expected hs=1 pc=bfc00000", snap_hs, snap_de_pc);
        end
        base = fire_cnt;
        repeat (6) tick();
        vectors++;
        if (fire_cnt - base != 1) begin
            miscompares++; $display("FAIL bp_refill_fires: got %0d, expected 1", fire_cnt - base);
        end
        vectors++;
        if (addr_log[addr_log.size()-1] !== 32'hBFC0_0010) begin
            miscompares++;
            $display("FAIL bp_refill_addr: got %h, expected bfc00010", addr_log[addr_log.size()-1]);
        end
        vectors++;
        if (fq_count !== 3'd4) begin
            miscompares++; $display("FAIL bp_refill_count: got %0d, expected 4", fq_count);
        end
    endtask

    task automatic test_redirect();
        bit found = 0;
        apply_reset();
        de_ready = 1'b1;
        mem_lat  = 3;
        for (int i = 0; i < 10 && fire_cnt < 2; i++) tick();
        vectors++;
        if (imem_req_valid !== 1'b0) begin
            miscompares++; $display("FAIL redir_two_outstanding: req_valid got %b, expected 0", imem_req_valid);
        end
        do_redirect(32'h8000_1000);
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = snap_hs;
        end
        vectors++;
        if (!found || snap_de_pc !== 32'h8000_1000) begin
            miscompares++;
            $display("FAIL redir_first_pc: got found=%b pc=%h, expected found=1 pc=80001000", found, snap_de_pc);
        end
        repeat (8) tick();
    endtask

    task automatic test_redirect_collision();
        int base;
        apply_reset();
        de_ready = 1'b0;
        tick();
        do_redirect(32'h0040_0000);
        vectors++;
        if ({snap_resp_valid, snap_fire} !== 2'b11) begin
            miscompares++;
            $display("FAIL coll_setup: got resp=%b fire=%b, expected resp=1 fire=1", snap_resp_valid, snap_fire);
        end
        base = fire_cnt;
        repeat (12) tick();
        vectors++;
        if (fire_cnt - base != 4) begin
            miscompares++; $display("FAIL coll_fires: got %0d, expected 4", fire_cnt - base);
        end
        vectors++;
        if (fq_count !== 3'd4 || imem_req_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL coll_full: got count=%0d req_valid=%b, expected count=4 req_valid=0", fq_count, imem_req_valid);
        end
        de_ready = 1'b1;
        repeat (6) tick();
    endtask

    task automatic test_wrap();
        apply_reset();
        de_ready = 1'b1;
        repeat (3) tick();
        do_redirect(32'hFFFF_FFFC);
        repeat (8) tick();
        vectors++;
        if (addr_log.size() < 2) begin
            miscompares++; $display("FAIL wrap_fires: got %0d requests, expected at least 2", addr_log.size());
        end else begin
            vectors++;
            if (addr_log[0] !== 32'hFFFF_FFFC || addr_log[1] !== 32'h0000_0000) begin
                miscompares++;
                $display("FAIL wrap_addr: got %h then %h, expected fffffffc then 00000000", addr_log[0], addr_log[1]);
            end
        end
    endtask

    task automatic test_latency();
        bit found = 0;
        apply_reset();
        de_ready = 1'b1;
        mem_lat  = 3;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            found = snap_resp_valid;
        end
        vectors++;
        if (!found) begin
            miscompares++; $display("FAIL lat_resp: no response within 10 cycles, expected one");
        end
`ifdef FETCH_BYPASS_EN
        vectors++;
        if (snap_de_valid !== 1'b1 || snap_de_inst !== inst_of(32'hBFC0_0000)) begin
            miscompares++;
            $display("FAIL lat_bypass: got de_valid=%b inst=%h, expected 1 and %h",
                     snap_de_valid, snap_de_inst, inst_of(32'hBFC0_0000));
        end
        vectors++;
        if (fq_count !== 3'd0) begin
            miscompares++; $display("FAIL lat_bypass_count: got %0d, expected 0", fq_count);
        end
`else
        vectors++;
        if (snap_de_valid !== 1'b0) begin
            miscompares++; $display("FAIL lat_same_cycle: de_valid got %b, expected 0", snap_de_valid);
        end
        tick();
        vectors++;
        if (snap_de_valid !== 1'b1 || snap_de_pc !== 32'hBFC0_0000) begin
            miscompares++;
            $display("FAIL lat_next_cycle: got de_valid=%b pc=%h, expected 1 and bfc00000", snap_de_valid, snap_de_pc);
        end
`endif
        repeat (4) tick();
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_reset();
        test_redirect();
        test_redirect_collision();
        test_wrap();
        test_latency();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
